otter_intr_ctrl: RTL and testbench

Debounced, maskable interrupt controller that sequences the OTTER MCU `intr` input from the dev-board buttons and other asynchronous event sources. It sits on the OTTER IOBUS beside the LED, switch and seven-segment ports. The MCU programs a mask, reads pending/ID status, and acknowledges through memory-mapped registers. The block holds `intr` until the handler acknowledges, then enforces a minimum re-arm gap.

---
 rtl/otter_intr_ctrl.sv | 170 +++++++++++++++++
 tb/tb_otter_intr_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: debounced, maskable interrupt controller on the OTTER IOBUS.
// Raw event sources are synchronised and debounced. A debounced rising edge
// latches a pending bit. Pending-and-unmasked bits raise intr, which is held
// until software acknowledges. A fixed re-arm gap follows each acknowledge.
// Ports:
//   clk, RST_n       clock, asynchronous active-low reset
//   src[N_SRC]       raw asynchronous event inputs (active-high)
//   iobus_addr/out   MCU address / write data, iobus_wr write strobe
//   iobus_in         combinational read data (0 when not addressed)
//   rd_hit           address matches MASK, PEND, ACK or STATUS
//   intr             registered interrupt request to the MCU
module otter_intr_ctrl #(
  parameter int unsigned N_SRC           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned GAP_CYCLES      = 8,
  parameter logic [31:0] BASE_ADDR       = 32'h1100C010
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic [N_SRC-1:0] src,
  input  logic [31:0]      iobus_addr,
  input  logic [31:0]      iobus_out,
  input  logic             iobus_wr,
  output logic [31:0]      iobus_in,
  output logic             rd_hit,
  output logic             intr
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  localparam logic [31:0] A_MASK = BASE_ADDR;
  localparam logic [31:0] A_PEND = BASE_ADDR + 32'd4;
  localparam logic [31:0] A_ACK  = BASE_ADDR + 32'd8;
  localparam logic [31:0] A_STAT = BASE_ADDR + 32'd12;

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_GAP} state_t;

  logic [N_SRC-1:0] r_sync1, r_sync2, r_deb, r_mask, r_pend;
  logic [DW-1:0]    r_db_cnt [N_SRC];
  logic [GW-1:0]    r_gap_cnt;
  state_t           r_state;
  logic             r_intr;

  logic             w_hit_mask, w_hit_pend, w_hit_ack, w_hit_stat;
  logic             w_wr_mask, w_wr_pend, w_wr_ack;
  logic [N_SRC-1:0] w_rise, w_clr, w_act;
  logic             w_any;
  logic [4:0]       w_id;
  logic [31:0]      w_status;
  logic             w_unused;

  // Exact 32-bit address decode
  assign w_hit_mask = (iobus_addr == A_MASK);
  assign w_hit_pend = (iobus_addr == A_PEND);
  assign w_hit_ack  = (iobus_addr == A_ACK);
  assign w_hit_stat = (iobus_addr == A_STAT);
  assign rd_hit     = w_hit_mask | w_hit_pend | w_hit_ack | w_hit_stat;

  assign w_wr_mask = iobus_wr & w_hit_mask;
  assign w_wr_pend = iobus_wr & w_hit_pend;
  assign w_wr_ack  = iobus_wr & w_hit_ack;

  // Upper write-data bits are ignored when N_SRC < 32
  assign w_unused = ^iobus_out;

  // Synchroniser and per-source debounce counters
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < int'(N_SRC); i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= src;
      r_sync2 <= r_sync1;
      for (int i = 0; i < int'(N_SRC); i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Rising edge detected on the same edge the debounced value is accepted
  always_comb begin
    w_rise = '0;
    for (int i = 0; i < int'(N_SRC); i++)
      w_rise[i] = r_sync2[i] & ~r_deb[i] & (r_db_cnt[i] == DB_LAST);
  end

  assign w_clr = w_wr_pend ? iobus_out[N_SRC-1:0] : '0;

  // MASK and PEND registers; a set event beats a same-cycle W1C
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_mask <= '0;
      r_pend <= '0;
    end else begin
      if (w_wr_mask) r_mask <= iobus_out[N_SRC-1:0];
      r_pend <= (r_pend & ~w_clr) | w_rise;
    end
  end

  assign w_act = r_pend & r_mask;
  assign w_any = |w_act;

  // Lowest active index (0 when nothing is active)
  always_comb begin
    w_id = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--)
      if (w_act[i]) w_id = 5'(i);
  end

  assign w_status = {w_any, 26'd0, w_id};

  // Read mux; ACK and unmapped addresses read 0
  always_comb begin
    iobus_in = '0;
    if (w_hit_mask)      iobus_in = 32'(r_mask);
    else if (w_hit_pend) iobus_in = 32'(r_pend);
    else if (w_hit_stat) iobus_in = w_status;
  end

  // Interrupt sequencer: IDLE -> FIRE -> (ACK) GAP -> IDLE
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
      r_intr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_FIRE;
            r_intr  <= 1'b1;
          end
        end
        S_FIRE: begin
          if (w_wr_ack) begin
            r_state   <= S_GAP;
            r_gap_cnt <= GAP_LAST;
            r_intr    <= 1'b0;
          end else if (!w_any) begin
            r_state <= S_IDLE;
            r_intr  <= 1'b0;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) r_state <= S_IDLE;
          else                 r_gap_cnt <= r_gap_cnt - GW'(1);
        end
        default: begin
          r_state <= S_IDLE;
          r_intr  <= 1'b0;
        end
      endcase
    end
  end

  assign intr = r_intr;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Testbench for otter_intr_ctrl: register-map vector table, directed
// multi-cycle sequences and a randomized run against a reference model.
module tb_otter_intr_ctrl;

  localparam int unsigned N = 5;
  localparam int unsigned D = 4;
  localparam int unsigned G = 8;
  localparam logic [31:0] BASE   = 32'h1100C010;
  localparam logic [31:0] A_MASK = BASE;
  localparam logic [31:0] A_PEND = BASE + 32'd4;
  localparam logic [31:0] A_ACK  = BASE + 32'd8;
  localparam logic [31:0] A_STAT = BASE + 32'd12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  src;
  logic [31:0]   addr, wdata, rdata;
  logic          wr, hit, intr;

  int n_chk  = 0;
  int n_pass = 0;

  otter_intr_ctrl #(
    .N_SRC(N), .DEBOUNCE_CYCLES(D), .GAP_CYCLES(G), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .RST_n(rst_n), .src(src),
    .iobus_addr(addr), .iobus_out(wdata), .iobus_wr(wr),
    .iobus_in(rdata), .rd_hit(hit), .intr(intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a;
    wr   = 1'b0;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic wreg(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
    wdata = '0;
  endtask

  task automatic chk_intr(input logic exp, input string name);
    check(name, 32'(intr), 32'(exp));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src   = '0;
    addr  = '0;
    wdata = '0;
    wr    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Debounce: a source flips when the last D synchronised samples all
  // disagree with its debounced value. Sample h[t] is src at edge t; the
  // comparison at edge t sees h[t-2], so the window is h[t-D-1 .. t-2].
  logic [N-1:0] m_hist [$];
  logic [N-1:0] m_deb, m_pend, m_mask;
  logic         m_intr;
  int           m_t, m_block;

  task automatic model_reset();
    m_hist.delete();
    for (int k = 0; k < int'(D) + 2; k++) m_hist.push_back('0);
    m_deb   = '0;
    m_pend  = '0;
    m_mask  = '0;
    m_intr  = 1'b0;
    m_t     = 0;
    m_block = -100;
  endtask

  task automatic model_step();
    logic         any;
    logic [N-1:0] nd, rise;
    any = |(m_pend & m_mask);
    m_t++;
    m_hist.push_back(src);
    if (m_hist.size() > int'(D) + 2) void'(m_hist.pop_front());
    nd = m_deb;
    for (int i = 0; i < int'(N); i++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int j = 0; j < int'(D); j++)
        if (m_hist[j][i] == m_deb[i]) all_diff = 1'b0;
      if (all_diff) nd[i] = ~m_deb[i];
    end
    rise  = nd & ~m_deb;
    m_deb = nd;
    if (wr && addr == A_PEND) m_pend = m_pend & ~wdata[N-1:0];
    m_pend = m_pend | rise;
    if (wr && addr == A_MASK) m_mask = wdata[N-1:0];
    // intr holds until ACK (then blocked for G edges) or nothing is active
    if (m_intr) begin
      if (wr && addr == A_ACK) begin
        m_intr  = 1'b0;
        m_block = m_t + int'(G);
      end else if (!any) begin
        m_intr = 1'b0;
      end
    end else if (any && m_t > m_block) begin
      m_intr = 1'b1;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0]  r;
    logic [N-1:0] act;
    int           idx;
    r   = '0;
    act = m_pend & m_mask;
    idx = -1;
    if (a == A_MASK) r = 32'(m_mask);
    else if (a == A_PEND) r = 32'(m_pend);
    else if (a == A_STAT && act != '0) begin
      for (int i = 0; i < int'(N); i++)
        if (act[i] && idx < 0) idx = i;
      r[31]  = 1'b1;
      r[4:0] = 5'(idx);
    end
    return r;
  endfunction

  // ---------------- register-map vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{A_MASK,        32'h0,        1'b0, 32'h0,  1'b1};
    tbl[1]  = '{A_MASK,        32'hFFFFFFFF, 1'b1, 32'h0,  1'b1};
    tbl[2]  = '{A_MASK,        32'h0,        1'b0, 32'h1F, 1'b1};
    tbl[3]  = '{A_PEND,        32'h0,        1'b0, 32'h0,  1'b1};
    tbl[4]  = '{A_PEND,        32'hFFFFFFFF, 1'b1, 32'h0,  1'b1};
    tbl[5]  = '{A_ACK,         32'h0,        1'b0, 32'h0,  1'b1};
    tbl[6]  = '{A_STAT,        32'h0,        1'b0, 32'h0,  1'b1};
    tbl[7]  = '{BASE - 32'd4,  32'h0,        1'b0, 32'h0,  1'b0};
    tbl[8]  = '{BASE + 32'd16, 32'h0,        1'b0, 32'h0,  1'b0};
    tbl[9]  = '{BASE + 32'd1,  32'h0,        1'b0, 32'h0,  1'b0};
    tbl[10] = '{A_MASK ^ 32'h80000000, 32'h0, 1'b1, 32'h0, 1'b0};
    tbl[11] = '{A_MASK,        32'h0,        1'b0, 32'h1F, 1'b1};
    tbl[12] = '{A_MASK,        32'h0000000A, 1'b1, 32'h1F, 1'b1};
    tbl[13] = '{A_MASK,        32'h0,        1'b0, 32'h0A, 1'b1};
    tbl[14] = '{A_MASK,        32'h0,        1'b0, 32'h0A, 1'b1};
    tbl[15] = '{A_STAT,        32'h0,        1'b0, 32'h0,  1'b1};

    // reset state, asserted from time 0
    rst_n = 1'b0; src = '0; addr = A_MASK; wdata = '0; wr = 1'b0;
    #3;
    chk_intr(1'b0, "reset_intr");
    check("reset_mask", rdata, 32'h0);
    do_reset();

    for (int v = 0; v < 16; v++) begin
      addr  = tbl[v].addr;
      wdata = tbl[v].data;
      wr    = tbl[v].wr;
      #1;
      check($sformatf("tbl%0d_rd", v), rdata, tbl[v].exp_rd);
      check($sformatf("tbl%0d_hit", v), 32'(hit), 32'(tbl[v].exp_hit));
      chk_intr(1'b0, $sformatf("tbl%0d_intr", v));
      tick();
      wr = 1'b0;
    end

    // basic fire: src[0] rises before edge 1
    do_reset();
    wreg(A_MASK, 32'h1);
    src[0] = 1'b1;
    repeat (5) tick();
    rd(A_PEND, 32'h0, "fire_pend_e5");
    tick();
    rd(A_PEND, 32'h1, "fire_pend_e6");
    chk_intr(1'b0, "fire_intr_e6");
    tick();
    chk_intr(1'b1, "fire_intr_e7");
    rd(A_STAT, 32'h80000000, "fire_status");

    // ack and re-arm gap
    wreg(A_ACK, 32'h0);
    chk_intr(1'b0, "ack_k");
    for (int j = 1; j <= int'(G); j++) begin
      tick();
      chk_intr(1'b0, $sformatf("gap_k%0d", j));
    end
    tick();
    chk_intr(1'b1, "refire_k9");
    rd(A_PEND, 32'h1, "ack_keeps_pend");
    wreg(A_PEND, 32'h1);
    chk_intr(1'b1, "w1c_edge_intr");
    rd(A_PEND, 32'h0, "w1c_pend");
    wreg(A_ACK, 32'h0);
    chk_intr(1'b0, "ack2_intr");
    repeat (12) tick();
    chk_intr(1'b0, "ack2_quiet");
    rd(A_PEND, 32'h0, "ack2_pend");

    // glitch reject: 3-cycle pulse rejected, 4-cycle pulse accepted
    wreg(A_MASK, 32'h3);
    src[1] = 1'b1;
    repeat (3) tick();
    src[1] = 1'b0;
    repeat (7) tick();
    rd(A_PEND, 32'h0, "glitch_pend");
    chk_intr(1'b0, "glitch_intr");
    src[1] = 1'b1;
    repeat (5) tick();
    rd(A_PEND, 32'h0, "pulse4_pend_e5");
    tick();
    rd(A_PEND, 32'h2, "pulse4_pend_e6");
    src[1] = 1'b0;
    tick();
    chk_intr(1'b1, "pulse4_intr");
    wreg(A_PEND, 32'h2);
    tick();
    chk_intr(1'b0, "pulse4_cleared");

    // falling edge ignored, then collision of W1C with a new rise
    src[0] = 1'b0;
    repeat (8) tick();
    rd(A_PEND, 32'h0, "fall_ignored");
    src[0] = 1'b1;
    repeat (5) tick();
    wreg(A_PEND, 32'h1);
    rd(A_PEND, 32'h1, "collision_set_wins");
    wreg(A_MASK, 32'h0);
    tick();
    chk_intr(1'b0, "collision_masked");
    wreg(A_PEND, 32'h1F);
    rd(A_PEND, 32'h0, "pend_cleared");

    // mask gating
    src[2] = 1'b1;
    repeat (8) tick();
    rd(A_PEND, 32'h4, "mask0_pend");
    rd(A_STAT, 32'h0, "mask0_status");
    chk_intr(1'b0, "mask0_intr");
    wreg(A_MASK, 32'h4);
    chk_intr(1'b0, "mask_k");
    tick();
    chk_intr(1'b1, "mask_k1");
    rd(A_STAT, 32'h80000002, "mask_status");
    wreg(A_MASK, 32'h0);
    chk_intr(1'b1, "unmask_j");
    tick();
    chk_intr(1'b0, "unmask_j1");

    // asynchronous reset in FIRE with a source still active
    wreg(A_MASK, 32'h4);
    tick();
    chk_intr(1'b1, "prereset_fire");
    src = 5'b00100;
    #1;
    rst_n = 1'b0;
    #1;
    chk_intr(1'b0, "areset_intr");
    rd(A_MASK, 32'h0, "areset_mask");
    rd(A_PEND, 32'h0, "areset_pend");
    rd(A_STAT, 32'h0, "areset_status");
    rst_n = 1'b1;
    wreg(A_MASK, 32'h4);
    for (int e = 2; e <= int'(D) + 2; e++) begin
      tick();
      chk_intr(1'b0, $sformatf("postreset_e%0d", e));
      if (e == int'(D) + 1) rd(A_PEND, 32'h0, "postreset_pend_early");
      if (e == int'(D) + 2) rd(A_PEND, 32'h4, "postreset_pend");
    end
    tick();
    chk_intr(1'b1, "postreset_fire");

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(N); i++)
        if ($urandom_range(0, 9) == 0) src[i] = ~src[i];
      case ($urandom_range(0, 5))
        0:       addr = A_MASK;
        1:       addr = A_PEND;
        2:       addr = A_ACK;
        3:       addr = A_STAT;
        4:       addr = BASE + 32'd16;
        default: addr = $urandom();
      endcase
      wr    = ($urandom_range(0, 4) == 0);
      wdata = $urandom();
      #1;
      check("rand_rd", rdata, m_read(addr));
      check("rand_hit", 32'(hit),
            32'(addr == A_MASK || addr == A_PEND || addr == A_ACK || addr == A_STAT));
      @(posedge clk);
      model_step();
      #1;
      check("rand_intr", 32'(intr), 32'(m_intr));
    end
    wr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
